// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared state encoding and datapath widths for the MAC scheduler.
package mac_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } mac_sched_state_t;

  localparam int unsigned MS_OPW         = 8;
  localparam int unsigned MS_ACCW        = 16;
  localparam int unsigned MS_MULT_CYCLES = 8;

endpackage

// File: rtl/mac_shift_mult.sv
// mac_shift_mult: sequential 8x8 shift-add multiplier.
// Operands are captured on start; one partial product is added per cycle for
// MS_MULT_CYCLES cycles. done is high in the cycle of the final add, so product
// holds the full result from the following cycle until the next start.
module mac_shift_mult
  import mac_sched_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [MS_OPW-1:0]  opa,
  input  logic [MS_OPW-1:0]  opb,
  output logic               done,
  output logic [MS_ACCW-1:0] product
);

  localparam int unsigned CNTW = $clog2(MS_MULT_CYCLES);
  localparam logic [CNTW-1:0] LAST = CNTW'(MS_MULT_CYCLES - 1);

  logic [MS_OPW-1:0]  a_sh;
  logic [MS_ACCW-1:0] b_sh;
  logic [CNTW-1:0]    cnt;
  logic               running;

  // Capture operands on start, then add opb<<k whenever opa[k] is set.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      running <= 1'b0;
      product <= '0;
    end else if (start) begin
      a_sh    <= opa;
      b_sh    <= MS_ACCW'(opb);
      cnt     <= '0;
      running <= 1'b1;
      product <= '0;
    end else if (running) begin
      if (a_sh[0]) begin
        product <= product + b_sh;
      end
      a_sh <= a_sh >> 1;
      b_sh <= b_sh << 1;
      cnt  <= cnt + 1'b1;
      if (cnt == LAST) begin
        running <= 1'b0;
      end
    end
  end

  assign done = running && (cnt == LAST);

endmodule

// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler sharing one shift-add MAC engine among
// NREQ requesters, each with a private 16-bit accumulator.
// Optional feature macro: MAC_SCHED_SAT_EN (saturating accumulate).
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MS_OPW-1:0] req_opa,
  input  logic [NREQ*MS_OPW-1:0] req_opb,
  input  logic [NREQ-1:0]        req_clr_acc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [MS_ACCW-1:0]     rsp_acc,
  output logic                   busy
);

  mac_sched_state_t state, state_next;

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_next;
  logic [IDW-1:0]     gid;
  logic               clr_flag;
  logic [MS_ACCW-1:0] acc [NREQ];

  logic               found;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     cand;
  int unsigned        idx;
  logic               grant;

  logic [MS_OPW-1:0]  sel_opa;
  logic [MS_OPW-1:0]  sel_opb;
  logic               mult_done;
  logic [MS_ACCW-1:0] mult_product;
  logic [MS_ACCW-1:0] acc_new;
`ifdef MAC_SCHED_SAT_EN
  logic [MS_ACCW:0]   acc_sum;
`else
  logic [MS_ACCW-1:0] acc_sum;
`endif

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign grant    = (state == IDLE) && found;
  assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign sel_opa  = req_opa[int'(grant_id) * MS_OPW +: MS_OPW];
  assign sel_opb  = req_opb[int'(grant_id) * MS_OPW +: MS_OPW];

  // Accept strobe back to the granted requester, only while idle.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  mac_shift_mult u_mult (
    .clk     (clk),
    .clr     (clr),
    .start   (grant),
    .opa     (sel_opa),
    .opb     (sel_opb),
    .done    (mult_done),
    .product (mult_product)
  );

  // FSM next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found)     state_next = MULT;
      MULT:    if (mult_done) state_next = ACC;
      ACC:                    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Accumulator update: overwrite on clear-accumulate, otherwise add (wrap or saturate).
  always_comb begin
    acc_sum = '0;
    acc_new = mult_product;
    if (!clr_flag) begin
`ifdef MAC_SCHED_SAT_EN
      acc_sum = {1'b0, acc[gid]} + {1'b0, mult_product};
      acc_new = acc_sum[MS_ACCW] ? '1 : acc_sum[MS_ACCW-1:0];
`else
      acc_sum = acc[gid] + mult_product;
      acc_new = acc_sum;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant capture, accumulator array and registered response/busy outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr       <= '0;
      gid       <= '0;
      clr_flag  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_acc   <= '0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        acc[i] <= '0;
      end
    end else begin
      busy      <= (state_next != IDLE);
      rsp_valid <= (state_next == RESP);
      if (grant) begin
        gid      <= grant_id;
        clr_flag <= req_clr_acc[grant_id];
        ptr      <= ptr_next;
      end
      if (state == ACC) begin
        acc[gid] <= acc_new;
        rsp_id   <= gid;
        rsp_acc  <= acc_new;
      end
    end
  end

endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: directed, table-driven bench for mac_sched (NREQ=4).
// Expected accumulator values are hand-computed; MAC_SCHED_SAT_EN selects the
// saturating expectation for the overflow vector.
module tb_mac_sched;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic [3:0]  req_clr_acc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_acc;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_sched #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .clr         (clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .req_clr_acc (req_clr_acc),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_acc     (rsp_acc),
    .busy        (busy)
  );

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_valid[id]        = 1'b1;
    req_opa[id*8 +: 8]   = a;
    req_opb[id*8 +: 8]   = b;
    req_clr_acc[id]      = c;
  endtask

  // Called right after driving at a negedge; returns in the accept cycle.
  task automatic wait_ready(input string name, input logic [3:0] exp, output int lat);
    lat = 0;
    #1;
    while (req_ready == 4'b0 && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({name, " grant"}, 32'(req_ready), 32'(exp));
  endtask

  // Drops the accepted request, scrambles its operands, and waits for the response.
  task automatic wait_rsp(input string name, input int id, input logic [15:0] eacc);
    int lat;
    @(negedge clk);
    req_valid[id]      = 1'b0;
    req_opa[id*8 +: 8] = 8'hA5;
    req_opb[id*8 +: 8] = 8'h5A;
    req_clr_acc[id]    = ~req_clr_acc[id];
    #1;
    lat = 1;
    chk({name, " mult busy/ready"}, 32'({busy, req_ready}), 32'({1'b1, 4'b0000}));
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({name, " rsp latency"}, 32'(lat), 32'd10);
    chk({name, " rsp_id"}, 32'(rsp_id), 32'(id));
    chk({name, " rsp_acc"}, 32'(rsp_acc), 32'(eacc));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    clr         = 1'b1;
    req_valid   = '0;
    req_clr_acc = '0;
    #1;
    chk({name, " reset outputs"}, 32'({busy, rsp_valid, rsp_id, rsp_acc, req_ready}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          seen;
    int          order [5];
    logic [15:0] racc  [5];

    vecs[0] = '{id: 0, a: 8'd12,  b: 8'd10,  c: 1'b0, exp: 16'd120};
    vecs[1] = '{id: 0, a: 8'd12,  b: 8'd10,  c: 1'b0, exp: 16'd240};
    vecs[2] = '{id: 0, a: 8'd3,   b: 8'd5,   c: 1'b1, exp: 16'd15};
    vecs[3] = '{id: 2, a: 8'd255, b: 8'd255, c: 1'b0, exp: 16'd65025};
`ifdef MAC_SCHED_SAT_EN
    vecs[4] = '{id: 2, a: 8'd255, b: 8'd255, c: 1'b0, exp: 16'd65535};
`else
    vecs[4] = '{id: 2, a: 8'd255, b: 8'd255, c: 1'b0, exp: 16'd64514};
`endif
    vecs[5] = '{id: 1, a: 8'd0,   b: 8'd200, c: 1'b0, exp: 16'd0};
    vecs[6] = '{id: 3, a: 8'd255, b: 8'd1,   c: 1'b1, exp: 16'd255};
    vecs[7] = '{id: 1, a: 8'd170, b: 8'd85,  c: 1'b0, exp: 16'd14450};
    vecs[8] = '{id: 2, a: 8'd1,   b: 8'd1,   c: 1'b1, exp: 16'd1};

    order = '{0, 1, 2, 3, 1};
    racc  = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd27};

    clr         = 1'b1;
    req_valid   = '0;
    req_opa     = '0;
    req_opb     = '0;
    req_clr_acc = '0;
    rsp_ready   = 1'b1;
    #1;
    chk("power-on reset outputs", 32'({busy, rsp_valid, rsp_id, rsp_acc, req_ready}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;

    // Single-requester vectors, back to back with rsp_ready held high.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].c);
      wait_ready($sformatf("vec%0d", i), 4'b0001 << vecs[i].id, lat);
      chk($sformatf("vec%0d accept latency", i), 32'(lat), 32'd0);
      wait_rsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].exp);
    end

    // Round robin from reset; requester 1 re-requests while 3 is still pending.
    do_reset("rr");
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive_req(i, 8'(i + 1), 8'd10, 1'b0);
    end
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      if (s == 3) drive_req(1, 8'd1, 8'd7, 1'b0);
      wait_ready($sformatf("rr%0d", s), 4'b0001 << order[s], lat);
      chk($sformatf("rr%0d accept latency", s), 32'(lat), 32'd0);
      wait_rsp($sformatf("rr%0d", s), order[s], racc[s]);
    end

    // Back-pressure: five RESP cycles with rsp_ready low and other requests pending.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(0, 8'd5, 8'd6, 1'b0);
    wait_ready("bp", 4'b0001, lat);
    wait_rsp("bp", 0, 16'd40);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        drive_req(1, 8'd2, 8'd3, 1'b0);
        drive_req(2, 8'd4, 8'd4, 1'b0);
      end
      #1;
      chk($sformatf("bp hold%0d", k), 32'({rsp_valid, busy, rsp_id, rsp_acc, req_ready}),
          32'({1'b1, 1'b1, 2'd0, 16'd40, 4'b0000}));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp release cycle", 32'({rsp_valid, req_ready}), 32'({1'b1, 4'b0000}));
    @(negedge clk);
    #1;
    chk("bp next accept", 32'({rsp_valid, req_ready}), 32'({1'b0, 4'b0010}));
    wait_rsp("bp req1", 1, 16'd33);
    @(negedge clk);
    wait_ready("bp req2", 4'b0100, lat);
    chk("bp req2 accept latency", 32'(lat), 32'd0);
    wait_rsp("bp req2", 2, 16'd46);

    // Reset four cycles into MULT: no response, accumulators cleared.
    @(negedge clk);
    drive_req(0, 8'd9, 8'd9, 1'b0);
    wait_ready("mid-reset", 4'b0001, lat);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("mid-reset outputs", 32'({busy, rsp_valid, rsp_id, rsp_acc, req_ready}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr  = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (rsp_valid || busy) seen++;
    end
    chk("mid-reset no response", 32'(seen), 32'd0);
    @(negedge clk);
    drive_req(0, 8'd2, 8'd2, 1'b0);
    wait_ready("post-reset", 4'b0001, lat);
    chk("post-reset accept latency", 32'(lat), 32'd0);
    wait_rsp("post-reset", 0, 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_sched.md
# mac_sched

Round-robin scheduler that shares one sequential 8x8 shift-add multiply-accumulate engine among `NREQ` requesters. Each requester has its own 16-bit accumulator. The scheduler grants one request at a time, runs the multiply over 8 cycles, and updates the owner's accumulator. It then returns the new accumulator value on a single response channel. It sits between the requester blocks and the arithmetic datapath, replacing a per-requester combinational MAC.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`: requester id width (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_opa`  in  NREQ*8  packed multiplicands; requester i uses bits [8i+7:8i].
- `req_opb`  in  NREQ*8  packed multipliers, same packing.
- `req_clr_acc`  in  NREQ  when set with an accepted request: acc = product instead of acc + product.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  requester whose accumulator is reported.
- `rsp_acc`  out  16  updated accumulator value.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Reset values:** state IDLE, all accumulators 0, RR pointer 0, `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_acc` 0, `busy` 0.
- **FSM:** IDLE -> MULT -> ACC -> RESP -> IDLE.
- **IDLE:**
  - Search `req_valid` starting at the RR pointer and wrapping modulo NREQ.
  - The first set bit g gets `req_ready[g]`=1 combinationally in the same cycle; the handshake completes at that edge.
  - Latch opa, opb, `req_clr_acc[g]` and g; set pointer = (g+1) mod NREQ; go to MULT.
  - With no valid request, remain in IDLE and leave the pointer unchanged.
- **MULT:** exactly 8 cycles. Cycle k (0..7) adds opb<<k to a 16-bit partial product when opa[k]=1. The result is the exact 16-bit product opa*opb.
- **ACC:** 1 cycle.
  - acc[g] = clr_flag ? product : acc[g] + product.
  - The sum wraps modulo 2^16 unless `MAC_SCHED_SAT_EN` is defined.
  - Load `rsp_id`=g and `rsp_acc`=new acc[g].
- **RESP:** `rsp_valid`=1. `rsp_id` and `rsp_acc` hold stable until the cycle `rsp_ready`=1, then go to IDLE with `rsp_valid` 0.
- `req_ready` is 0 in MULT, ACC and RESP. Requesters hold `req_valid` and operands until accepted.
- Operand changes after acceptance have no effect on the operation in flight.
- **Reset mid-operation:** the in-flight operation is discarded, no response is produced, and all accumulators return to 0.

## Timing
- Accept in cycle T; MULT occupies T+1..T+8; ACC at T+9; `rsp_valid` first high at T+10.
- If `rsp_ready`=1 at T+10, the state is IDLE at T+11 and the earliest next accept is T+11.
- Minimum service interval is 11 cycles per request.
- `rsp_valid`, `rsp_id`, `rsp_acc` and `busy` are registered outputs.
- `req_ready` is combinational from `req_valid`, the pointer and the state. There is no combinational path from `rsp_ready` to `req_ready`.

## Configuration
- `MAC_SCHED_SAT_EN`:
  - Defined: the ACC update saturates at 16'hFFFF on unsigned overflow (a clear-accumulate result cannot overflow).
  - Undefined: the update wraps modulo 2^16.
  - No other behaviour changes.

## Structure
- Package `mac_sched_pkg` contains:
  - state enum `mac_sched_state_t` (IDLE, MULT, ACC, RESP);
  - constants `MS_OPW`=8, `MS_ACCW`=16, `MS_MULT_CYCLES`=8.
- Sub-module `mac_shift_mult`: 8-cycle shift-add multiplier with `start`, `opa`, `opb`, `done` pulse and a 16-bit `product`. It uses `clk` and `clr` like the parent.
- The scheduler FSM, RR pointer and accumulator array live in `mac_sched`.

## Test plan
- **Single requester:** requester 0 sends opa=12, opb=10, clr_acc=0 twice, `rsp_ready` held 1. Responses are id=0, acc=120, then acc=240. `rsp_valid` rises 10 cycles after each accept.
- **Clear-accumulate:** after acc[0]=240, send opa=3, opb=5, clr_acc=1. Response acc=15.
- **Round robin:** all four `req_valid` set from reset, each with opa=i+1 and opb=10. Grants go in order 0, 1, 2, 3, with responses acc=10, 20, 30, 40. A following request from 3 plus 1 is granted to 1 only after 3 is served.
- **Overflow:** requester 2 sends opa=255, opb=255 twice. The second response is acc=64514 without `MAC_SCHED_SAT_EN` and acc=65535 with it.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles in RESP. `rsp_id`/`rsp_acc` stay stable, `req_ready` stays 0 despite pending requests, and the next accept comes the cycle after `rsp_ready`=1.
- **Reset mid-MULT:** assert `clr` 4 cycles after an accept. There is no response, all outputs take their reset values immediately, and a subsequent opa=2, opb=2 request returns acc=4.
